// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and imem write port bundle for imem_loader
//
// Signals:
//   rx_data   8   incoming byte from the host link
//   rx_valid  1   rx_data valid
//   rx_ready  1   loader accepts rx_data this cycle
//   we        1   imem write enable, one pulse per word
//   waddr     32  imem byte address
//   wdata     32  assembled little-endian instruction word
// Modports:
//   master  host side: drives rx_data/rx_valid, observes the rest
//   slave   loader side: consumes the byte stream, drives the write port
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader assembling a byte stream into imem word writes
//
// Frame: LEN_LO, LEN_HI (word count N), N*4 data bytes LSB first, then one
// XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse starting a load session (ignored while busy)
//   bus         imem_loader_if.slave: byte stream in, imem write port out
//   busy        session in progress
//   done        load completed, held until the next start
//   error       load aborted (length too large or bad checksum), held until next start
//   words_done  words written in the current or last session
// Parameters:
//   MEM_DEPTH   maximum loadable word count
//   BASE_ADDR   byte address of the first word (word aligned)
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  words_done
);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);

    state_t      state, state_next;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic        xfer;
    logic [15:0] len_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign bus.rx_ready = (state == LEN0) || (state == LEN1) ||
                          (state == DATA) || (state == CSUM);
    assign bus.we       = (state == WRITE);
    assign busy         = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done         = (state == DONE);
    assign error        = (state == ERR);
    assign xfer         = bus.rx_valid && bus.rx_ready;
    // Complete length as it becomes known on the LEN_HI transfer.
    assign len_full     = {bus.rx_data, len[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_next = LEN0;
            end
            LEN0: begin
                if (xfer) state_next = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else if ({1'b0, len_full} > DEPTH_LIM) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                // words_done still holds the pre-increment count here.
                if (words_done + 16'd1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) state_next = (bus.rx_data == csum) ? DONE : ERR;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= 16'd0;
            byte_idx   <= 2'd0;
            bus.wdata  <= 32'd0;
            bus.waddr  <= BASE_ADDR;
            words_done <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_idx   <= 2'd0;
                        bus.waddr  <= BASE_ADDR;
                        words_done <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end
                LEN0: begin
                    if (xfer) len[7:0] <= bus.rx_data;
                end
                LEN1: begin
                    if (xfer) len[15:8] <= bus.rx_data;
                end
                DATA: begin
                    if (xfer) begin
                        bus.wdata[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.rx_data;
`endif
                    end
                end
                WRITE: begin
                    // Address advances after the pulse so we sees the current one.
                    words_done <= words_done + 16'd1;
                    bus.waddr  <= bus.waddr + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;

    imem_loader_if bus ();

    imem_loader #(
        .MEM_DEPTH (32),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] frame_q[$];
    logic [63:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n && bus.we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: got waddr %h wdata %h expected no write",
                         bus.waddr, bus.wdata);
            end else begin
                exp_e = exp_q.pop_front();
                check("waddr", bus.waddr, exp_e[63:32]);
                check("wdata", bus.wdata, exp_e[31:0]);
                check("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 expected 1 within 100 cycles");
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Sends LEN, the words in frame_q and (if enabled) checksum ^ csum_delta;
    // pushes the expected writes into the scoreboard.
    task automatic send_frame(input int n_len, input logic [7:0] csum_delta, input bit gaps);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        send_byte(n_len[7:0], 0);
        send_byte(n_len[15:8], 0);
        for (int i = 0; i < frame_q.size(); i++) begin
            w = frame_q[i];
            exp_q.push_back({32'(4 * i), w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
                x = x ^ w[8*k +: 8];
            end
        end
        if (CSUM_EN) send_byte(x ^ csum_delta, 0);
        frame_q.delete();
    endtask

    task automatic wait_end();
        int c;
        c = 0;
        while (!(done || error) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL session_timeout: got done 0 error 0 expected completion");
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_waddr", bus.waddr, 32'h0);
        rst_n = 1'b1;

        // 1: reset mid-DATA aborts immediately, no write afterwards.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h57, 0);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r1_busy", 32'(busy), 32'd0);
        check("r1_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("r1_we", 32'(bus.we), 32'd0);
        check("r1_wdata", bus.wdata, 32'h0);
        check("r1_waddr", bus.waddr, 32'h0);
        check("r1_words_done", 32'(words_done), 32'd0);
        check("r1_done_error", {30'd0, done, error}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("r1_idle_after", 32'(busy), 32'd0);

        // 2: single word 0x00000013.
        pulse_start();
        frame_q.push_back(32'h0000_0013);
        send_frame(1, 8'h00, 1'b0);
        wait_end();
        check("t2_done", 32'(done), 32'd1);
        check("t2_error", 32'(error), 32'd0);
        check("t2_words_done", 32'(words_done), 32'd1);
        repeat (5) @(negedge clk);
        check("t2_done_sticky", 32'(done), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // 3: three words with random rx_valid gaps.
        pulse_start();
        check("t3_done_cleared", 32'(done), 32'd0);
        frame_q.push_back(32'h0041_8293);
        frame_q.push_back(32'h4094_0393);
        frame_q.push_back(32'h0041_C433);
        send_frame(3, 8'h00, 1'b1);
        wait_end();
        check("t3_done", 32'(done), 32'd1);
        check("t3_words_done", 32'(words_done), 32'd3);

        // 4: N=33 exceeds depth -> error, then restart.
        pulse_start();
        send_byte(8'h21, 0);
        send_byte(8'h00, 0);
        check("t4_error", 32'(error), 32'd1);
        check("t4_done", 32'(done), 32'd0);
        check("t4_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("t4_words_done", 32'(words_done), 32'd0);
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);

        // 5: N=0 completes without writes.
        send_frame(0, 8'h00, 1'b0);
        wait_end();
        check("t5_done", 32'(done), 32'd1);
        check("t5_words_done", 32'(words_done), 32'd0);

        // Boundary: N=MEM_DEPTH fills memory, last address 124.
        pulse_start();
        for (int i = 0; i < 32; i++) frame_q.push_back($urandom);
        send_frame(32, 8'h00, 1'b0);
        wait_end();
        check("full_done", 32'(done), 32'd1);
        check("full_words_done", 32'(words_done), 32'd32);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch.
        pulse_start();
        frame_q.push_back(32'h0000_0013);
        send_frame(1, 8'h00, 1'b0);
        wait_end();
        check("t6_good_done", 32'(done), 32'd1);
        pulse_start();
        frame_q.push_back(32'h0000_0013);
        send_frame(1, 8'h01, 1'b0);
        wait_end();
        check("t6_bad_error", 32'(error), 32'd1);
        check("t6_bad_done", 32'(done), 32'd0);
        check("t6_bad_words", 32'(words_done), 32'd1);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
